// File: rtl/issue_ctrl_if.sv
// Decode-to-issue and issue-to-unit handshake bundle for issue_ctrl.
// The master side drives decode offers and unit readiness; the slave side is the controller.
interface issue_ctrl_if;
    // Decode channel
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_wr_rd;
    logic [1:0]  id_unit;
    logic [31:0] id_payload;

    // Execute channel
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  ex_unit;
    logic [31:0] ex_payload;

    modport master (
        output id_valid,
        input  id_ready,
        output id_rs,
        output id_rt,
        output id_rd,
        output id_use_rs,
        output id_use_rt,
        output id_wr_rd,
        output id_unit,
        output id_payload,
        input  ex_valid,
        output ex_ready,
        input  ex_unit,
        input  ex_payload
    );

    modport slave (
        input  id_valid,
        output id_ready,
        input  id_rs,
        input  id_rt,
        input  id_rd,
        input  id_use_rs,
        input  id_use_rt,
        input  id_wr_rd,
        input  id_unit,
        input  id_payload,
        output ex_valid,
        input  ex_ready,
        output ex_unit,
        output ex_payload
    );
endinterface

// File: rtl/issue_ctrl.sv
// Issue-stage controller: one-entry instruction buffer, scoreboard hazard checks
// (RAW, WAW, writeback slot) and destination claim on the issuing edge.
module issue_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    issue_ctrl_if.slave bus,

    output logic [4:0]  iss_ass_addr_a,
    output logic [4:0]  iss_ass_addr_b,
    input  logic        iss_ass_pending_a,
    input  logic        iss_ass_pending_b,
    input  logic [1:0]  iss_ass_unit_a,
    input  logic [1:0]  iss_ass_unit_b,
    input  logic [4:0]  iss_ass_row_a,
    input  logic [4:0]  iss_ass_row_b,

    output logic [4:0]  wb_ass_addr,
    input  logic        wb_ass_pending,
    input  logic [4:0]  wb_ass_row,

    output logic [4:0]  writeaddr,
    output logic [1:0]  registerunit,
    output logic        enablewrite,
    input  logic [31:0] sb_haz_column,

    output logic [15:0] stall_cycles
);

    localparam logic [1:0] UnitAluMisc = 2'b00;
    localparam logic [1:0] UnitMem     = 2'b01;
    localparam logic [1:0] UnitMult    = 2'b10;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e      state_q, state_d;
    logic [4:0]  rs_q, rt_q, rd_q;
    logic        use_rs_q, use_rt_q, wr_rd_q;
    logic [1:0]  unit_q;
    logic [31:0] payload_q;
    logic [15:0] stall_q, stall_d;

    logic        full;
    logic        accept;
    logic        fire;
    logic        haz_a, haz_b, haz_waw, haz_struct, unit_illegal;
    logic        hazard;
    logic [4:0]  slot_mask;

    // Unit field of the source entries is not needed: any pending non-bypassable row stalls.
    logic unused_inputs;
    assign unused_inputs = ^{iss_ass_unit_a, iss_ass_unit_b, iss_ass_row_a[0], iss_ass_row_b[0]};

    assign full = (state_q == StFull);

    // Row bit 0 means the producer's result is on the bypass this cycle, so it is not a hazard.
    assign haz_a = use_rs_q & (rs_q != 5'd0) & iss_ass_pending_a & (|iss_ass_row_a[4:1]);
    assign haz_b = use_rt_q & (rt_q != 5'd0) & iss_ass_pending_b & (|iss_ass_row_b[4:1]);

    // Writeback slots at or beyond this unit's latency would collide or reorder (WAW).
    always_comb begin
        slot_mask    = 5'b00000;
        unit_illegal = 1'b0;
        unique case (unit_q)
            UnitAluMisc: slot_mask = 5'b11110;
            UnitMem:     slot_mask = 5'b11100;
            UnitMult:    slot_mask = 5'b10000;
            default:     unit_illegal = 1'b1;
        endcase
    end

    assign haz_waw    = wr_rd_q & (rd_q != 5'd0) & wb_ass_pending & (|(wb_ass_row & slot_mask));
    assign haz_struct = |sb_haz_column;
    assign hazard     = haz_a | haz_b | haz_waw | haz_struct | unit_illegal;

    assign bus.ex_valid   = full & ~hazard & ~flush;
    assign fire           = bus.ex_valid & bus.ex_ready;
    assign bus.id_ready   = ~flush & (full ? fire : 1'b1);
    assign accept         = bus.id_valid & bus.id_ready;
    assign bus.ex_unit    = unit_q;
    assign bus.ex_payload = payload_q;

    assign enablewrite    = fire & wr_rd_q & (rd_q != 5'd0);
    assign writeaddr      = rd_q;
    assign registerunit   = full ? unit_q : 2'b00;

    assign iss_ass_addr_a = full ? rs_q : 5'd0;
    assign iss_ass_addr_b = full ? rt_q : 5'd0;
    assign wb_ass_addr    = full ? rd_q : 5'd0;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else if (accept) begin
            state_d = StFull;
        end else if (fire) begin
            state_d = StEmpty;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (full && !fire && !flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            rd_q      <= 5'd0;
            use_rs_q  <= 1'b0;
            use_rt_q  <= 1'b0;
            wr_rd_q   <= 1'b0;
            unit_q    <= 2'b00;
            payload_q <= 32'd0;
        end else if (accept) begin
            rs_q      <= bus.id_rs;
            rt_q      <= bus.id_rt;
            rd_q      <= bus.id_rd;
            use_rs_q  <= bus.id_use_rs;
            use_rt_q  <= bus.id_use_rt;
            wr_rd_q   <= bus.id_wr_rd;
            unit_q    <= bus.id_unit;
            payload_q <= bus.id_payload;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl; the scoreboard is played by hand-written row values.
module tb_issue_ctrl;

    logic        clock;
    logic        reset;
    logic        flush;
    logic [4:0]  iss_ass_addr_a, iss_ass_addr_b;
    logic        iss_ass_pending_a, iss_ass_pending_b;
    logic [1:0]  iss_ass_unit_a, iss_ass_unit_b;
    logic [4:0]  iss_ass_row_a, iss_ass_row_b;
    logic [4:0]  wb_ass_addr;
    logic        wb_ass_pending;
    logic [4:0]  wb_ass_row;
    logic [4:0]  writeaddr;
    logic [1:0]  registerunit;
    logic        enablewrite;
    logic [31:0] sb_haz_column;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    issue_ctrl_if bus ();

    issue_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .bus               (bus.slave),
        .iss_ass_addr_a    (iss_ass_addr_a),
        .iss_ass_addr_b    (iss_ass_addr_b),
        .iss_ass_pending_a (iss_ass_pending_a),
        .iss_ass_pending_b (iss_ass_pending_b),
        .iss_ass_unit_a    (iss_ass_unit_a),
        .iss_ass_unit_b    (iss_ass_unit_b),
        .iss_ass_row_a     (iss_ass_row_a),
        .iss_ass_row_b     (iss_ass_row_b),
        .wb_ass_addr       (wb_ass_addr),
        .wb_ass_pending    (wb_ass_pending),
        .wb_ass_row        (wb_ass_row),
        .writeaddr         (writeaddr),
        .registerunit      (registerunit),
        .enablewrite       (enablewrite),
        .sb_haz_column     (sb_haz_column),
        .stall_cycles      (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic offer(input logic [1:0] unit, input logic [4:0] rd, input logic wr,
                         input logic [4:0] rs, input logic use_rs, input logic [31:0] pl);
        bus.id_valid   = 1'b1;
        bus.id_unit    = unit;
        bus.id_rd      = rd;
        bus.id_wr_rd   = wr;
        bus.id_rs      = rs;
        bus.id_use_rs  = use_rs;
        bus.id_rt      = 5'd0;
        bus.id_use_rt  = 1'b0;
        bus.id_payload = pl;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        bus.id_valid = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_rd = 5'd0;
        bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0; bus.id_wr_rd = 1'b0;
        bus.id_unit = 2'b00; bus.id_payload = 32'd0; bus.ex_ready = 1'b1;
        iss_ass_pending_a = 1'b0; iss_ass_pending_b = 1'b0;
        iss_ass_unit_a = 2'b00; iss_ass_unit_b = 2'b00;
        iss_ass_row_a = 5'd0; iss_ass_row_b = 5'd0;
        wb_ass_pending = 1'b0; wb_ass_row = 5'd0; sb_haz_column = 32'd0;

        // Reset state
        #3;
        chk("rst_id_ready", bus.id_ready, 1);
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_enablewrite", enablewrite, 0);
        chk("rst_writeaddr", writeaddr, 0);
        chk("rst_registerunit", registerunit, 0);
        chk("rst_stall", stall_cycles, 0);
        tick();
        reset = 1'b1;
        tick();

        // Back-to-back independent ALU ops
        offer(2'b00, 5'd1, 1'b1, 5'd0, 1'b0, 32'hA000_0001);
        settle();
        chk("b2b_empty_ex_valid", bus.ex_valid, 0);
        tick();
        offer(2'b00, 5'd2, 1'b1, 5'd0, 1'b0, 32'hA000_0002);
        settle();
        chk("b2b1_ex_valid", bus.ex_valid, 1);
        chk("b2b1_enablewrite", enablewrite, 1);
        chk("b2b1_writeaddr", writeaddr, 1);
        chk("b2b1_registerunit", registerunit, 0);
        chk("b2b1_id_ready", bus.id_ready, 1);
        tick();
        offer(2'b00, 5'd3, 1'b1, 5'd0, 1'b0, 32'hA000_0003);
        settle();
        chk("b2b2_enablewrite", enablewrite, 1);
        chk("b2b2_writeaddr", writeaddr, 2);
        tick();
        bus.id_valid = 1'b0;
        settle();
        chk("b2b3_enablewrite", enablewrite, 1);
        chk("b2b3_writeaddr", writeaddr, 3);
        chk("b2b3_payload", bus.ex_payload, 32'hA000_0003);
        tick();
        chk("b2b_done_ex_valid", bus.ex_valid, 0);
        chk("b2b_stall", stall_cycles, 0);

        // Mult to r5 then ALU consumer of r5
        offer(2'b10, 5'd5, 1'b1, 5'd0, 1'b0, 32'hB000_0005);
        tick();
        offer(2'b00, 5'd6, 1'b1, 5'd5, 1'b1, 32'hB000_0006);
        settle();
        chk("mult_enablewrite", enablewrite, 1);
        chk("mult_writeaddr", writeaddr, 5);
        chk("mult_registerunit", registerunit, 2);
        chk("mult_ex_unit", bus.ex_unit, 2);
        tick();
        bus.id_valid = 1'b0;
        iss_ass_pending_a = 1'b1;
        iss_ass_unit_a = 2'b10;
        iss_ass_row_a = 5'b10000;
        settle();
        chk("raw_addr_a", iss_ass_addr_a, 5);
        chk("raw_r10000", bus.ex_valid, 0);
        tick();
        iss_ass_row_a = 5'b01000;
        settle();
        chk("raw_r01000", bus.ex_valid, 0);
        tick();
        iss_ass_row_a = 5'b00100;
        settle();
        chk("raw_r00100", bus.ex_valid, 0);
        tick();
        iss_ass_row_a = 5'b00010;
        settle();
        chk("raw_r00010", bus.ex_valid, 0);
        chk("raw_no_claim", enablewrite, 0);
        tick();
        iss_ass_row_a = 5'b00001;
        settle();
        chk("raw_bypass_ex_valid", bus.ex_valid, 1);
        chk("raw_bypass_writeaddr", writeaddr, 6);
        chk("raw_stall", stall_cycles, 4);
        tick();
        iss_ass_pending_a = 1'b0;
        iss_ass_row_a = 5'd0;

        // r0 source and destination are never hazards or claims
        offer(2'b00, 5'd0, 1'b1, 5'd0, 1'b1, 32'hC000_0000);
        tick();
        bus.id_valid = 1'b0;
        iss_ass_pending_a = 1'b1;
        iss_ass_row_a = 5'b10000;
        wb_ass_pending = 1'b1;
        wb_ass_row = 5'b11111;
        settle();
        chk("r0_ex_valid", bus.ex_valid, 1);
        chk("r0_enablewrite", enablewrite, 0);
        tick();
        iss_ass_pending_a = 1'b0; iss_ass_row_a = 5'd0;
        wb_ass_pending = 1'b0; wb_ass_row = 5'd0;

        // Structural hazard for 2 cycles
        offer(2'b00, 5'd8, 1'b1, 5'd0, 1'b0, 32'hD000_0008);
        tick();
        bus.id_valid = 1'b0;
        sb_haz_column = 32'h0000_0100;
        settle();
        chk("struct_c1", bus.ex_valid, 0);
        tick();
        settle();
        chk("struct_c2", bus.ex_valid, 0);
        tick();
        sb_haz_column = 32'd0;
        settle();
        chk("struct_fire", enablewrite, 1);
        chk("struct_stall", stall_cycles, 6);
        tick();

        // WAW: Mem to r7 while r7 writeback row is occupied
        offer(2'b01, 5'd7, 1'b1, 5'd0, 1'b0, 32'hD000_0007);
        tick();
        bus.id_valid = 1'b0;
        wb_ass_pending = 1'b1;
        wb_ass_row = 5'b01000;
        settle();
        chk("waw_addr", wb_ass_addr, 7);
        chk("waw_r01000", bus.ex_valid, 0);
        tick();
        wb_ass_row = 5'b00100;
        settle();
        chk("waw_r00100", bus.ex_valid, 0);
        tick();
        wb_ass_row = 5'b00010;
        settle();
        chk("waw_fire", enablewrite, 1);
        chk("waw_registerunit", registerunit, 1);
        chk("waw_stall", stall_cycles, 8);
        tick();
        wb_ass_pending = 1'b0; wb_ass_row = 5'd0;

        // Unit back-pressure
        offer(2'b00, 5'd9, 1'b1, 5'd0, 1'b0, 32'hE000_0009);
        tick();
        offer(2'b00, 5'd10, 1'b1, 5'd0, 1'b0, 32'hE000_000A);
        bus.ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_ex_valid", bus.ex_valid, 1);
            chk("bp_payload", bus.ex_payload, 32'hE000_0009);
            chk("bp_id_ready", bus.id_ready, 0);
            chk("bp_no_claim", enablewrite, 0);
            tick();
        end
        bus.ex_ready = 1'b1;
        settle();
        chk("bp_fire", enablewrite, 1);
        chk("bp_writeaddr", writeaddr, 9);
        chk("bp_stall", stall_cycles, 11);
        tick();
        bus.id_valid = 1'b0;
        settle();
        chk("bp_next_writeaddr", writeaddr, 10);
        chk("bp_next_payload", bus.ex_payload, 32'hE000_000A);
        tick();

        // Illegal unit stalls until flushed
        offer(2'b11, 5'd11, 1'b1, 5'd0, 1'b0, 32'hF000_000B);
        tick();
        bus.id_valid = 1'b0;
        settle();
        chk("ill_c1", bus.ex_valid, 0);
        tick();
        settle();
        chk("ill_c2", bus.ex_valid, 0);
        tick();
        flush = 1'b1;
        settle();
        chk("flush_ex_valid", bus.ex_valid, 0);
        chk("flush_id_ready", bus.id_ready, 0);
        chk("flush_enablewrite", enablewrite, 0);
        tick();
        flush = 1'b0;
        settle();
        chk("post_flush_id_ready", bus.id_ready, 1);
        chk("post_flush_registerunit", registerunit, 0);
        chk("post_flush_wb_addr", wb_ass_addr, 0);
        chk("post_flush_stall", stall_cycles, 13);

        // Asynchronous reset mid-stall
        offer(2'b00, 5'd12, 1'b1, 5'd0, 1'b0, 32'h1234_5678);
        tick();
        bus.id_valid = 1'b0;
        sb_haz_column = 32'h0000_0001;
        tick();
        chk("pre_rst_stall", stall_cycles, 14);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_id_ready", bus.id_ready, 1);
        chk("arst_ex_valid", bus.ex_valid, 0);
        chk("arst_enablewrite", enablewrite, 0);
        chk("arst_writeaddr", writeaddr, 0);
        chk("arst_registerunit", registerunit, 0);
        chk("arst_stall", stall_cycles, 0);
        chk("arst_payload", bus.ex_payload, 0);
        tick();
        reset = 1'b1;
        sb_haz_column = 32'd0;
        tick();
        chk("after_rst_ex_valid", bus.ex_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Issue-stage controller: the writer and reader of the scoreboard. It buffers one decoded instruction and reads the scoreboard for source RAW, destination WAW and writeback-slot hazards. When the instruction is hazard-free and the functional unit is ready, it issues the instruction and claims the destination row in the same edge. It sits between decode (valid/ready) and the AluMisc/Mem/Mult units.

## Interface
- No parameters. Unit latencies are fixed: AluMisc (2'b00) L=1, Mem (2'b01) L=2, Mult (2'b10) L=4.
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous; drops the buffered instruction.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  buffer can accept.
- id_rs, id_rt, id_rd  in  5 each  source/destination register numbers.
- id_use_rs, id_use_rt, id_wr_rd  in  1 each  operand/destination used.
- id_unit  in  2  target unit; 2'b11 is illegal.
- id_payload  in  32  opaque instruction bits, passed through.
- ex_valid  out  1  instruction issued this cycle.
- ex_ready  in  1  target unit accepts.
- ex_unit  out  2  buffered unit.
- ex_payload  out  32  buffered payload.
- iss_ass_addr_a, iss_ass_addr_b  out  5 each  scoreboard read addresses (buffered rs/rt).
- iss_ass_pending_a/b  in  1; iss_ass_unit_a/b  in  2; iss_ass_row_a/b  in  5  scoreboard source entries.
- wb_ass_addr  out  5  scoreboard read address (buffered rd); wb_ass_pending  in  1; wb_ass_row  in  5.
- writeaddr  out  5; registerunit  out  2; enablewrite  out  1  scoreboard claim port.
- sb_haz_column  in  32  scoreboard column for registerunit.
- stall_cycles  out  16  saturating count of stalled cycles.

## Operation
- Two states. EMPTY: id_ready=1. FULL: id_ready=fire, where fire = ex_valid & ex_ready.
- Accept (id_valid & id_ready): buffer all id_* fields; state=FULL. If fire and accept occur in the same cycle, the new instruction replaces the old one and the state stays FULL. If fire occurs without accept, the state goes to EMPTY.
- Source hazard for operand x: used, reg≠0, pending, and row[4:1]≠0. row==5'b00001 counts as ready, because the result is bypassed.
- Destination WAW hazard: wr_rd, rd≠0, wb_ass_pending, and wb_ass_row has any bit at position ≥ L(unit).
- Structural hazard: |sb_haz_column.
- ex_valid = FULL & no hazards & ~flush.
- enablewrite = fire & wr_rd & (rd≠0). writeaddr = buffered rd. registerunit = buffered unit when FULL, otherwise 2'b00.
- iss_ass_addr_a/b and wb_ass_addr are driven from buffered fields, or 0 when EMPTY.
- flush: state=EMPTY next edge; ex_valid=0 and enablewrite=0 that cycle; id_ready=0 that cycle.
- Illegal unit 2'b11: the instruction never issues (treated as a permanent stall) until flushed.
- stall_cycles increments every cycle with FULL & ~fire & ~flush, and saturates at 16'hFFFF.

## Timing
- Reset: state EMPTY, buffer cleared, id_ready=1, ex_valid=0, enablewrite=0, writeaddr=0, registerunit=0, stall_cycles=0.
- Reset asserted mid-hold discards the instruction immediately, without a claim.
- Latency: accepted at edge N gives earliest fire in cycle N+1. Throughput is 1 instruction/cycle when hazard-free.
- Hazard and issue logic is combinational from buffer + scoreboard. The scoreboard claim and the state update occur on the same edge as fire.
- ex_payload and ex_unit are stable while ex_valid=1 and ex_ready=0.

## Test plan
- Back-to-back independent ALU ops (rd=1,2,3), ex_ready=1 -> one fire per cycle from N+1; enablewrite pulses with writeaddr 1,2,3 and registerunit 00; stall_cycles=0.
- Mult to r5, then ALU reading r5 -> consumer stalls while scoreboard row r5 is 10000/01000/00100/00010 (4 cycles); it fires when row=00001; stall_cycles=4.
- ALU with rd=0 and use_rs with rs=0 while r0 is "pending" -> fires immediately; enablewrite=0.
- sb_haz_column=32'h0000_0100 for 2 cycles -> ex_valid=0 for those cycles, fire the following cycle; WAW case: Mem to r7 while r7 row=01000 -> stalls until row≤00010.
- ex_ready=0 for 3 cycles with no hazard -> ex_valid=1 held, payload constant, id_ready=0, no claim; fire on the cycle ex_ready=1.
- flush while FULL and stalled -> no fire, EMPTY next cycle; reset asserted mid-stall -> all outputs at reset values asynchronously.
